iir_out_buffer: RTL and testbench
=================================

Name: iir_out_buffer

Overview:
Downstream stage of the IIR filter. Captures each filtered sample (Yn, WAddr) that the filter qualifies with WEN and buffers it in a small FIFO. Drains the FIFO to the result memory through a valid/ready write port. Tracks sample count, peak magnitude and overflow, and raises done once the filter reports Finish and every buffered sample has been written.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
AW, 20, address width; matches filter WAddr.
DW, 16, sample width; matches filter Yn.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low.
WEN  in  1  filter sample-valid; Yn/WAddr meaningful when 1.
Yn  in  DW  filtered sample, two's complement.
WAddr  in  AW  destination address of Yn.
Finish  in  1  filter end-of-stream flag, level.
mem_ready  in  1  memory accepts a write this cycle.
mem_wr  out  1  write request; equals FIFO not-empty.
mem_addr  out  AW  head-entry address.
mem_data  out  DW  head-entry sample.
ovf  out  1  sticky; a sample was dropped.
peak  out  DW  max |Yn| over accepted samples, unsigned.
sample_cnt  out  AW  accepted-sample count.
done  out  1  stream complete and drained.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, read/write pointers 0; all outputs 0; state IDLE.
- FIFO storage: {WAddr, Yn} per entry, DEPTH entries, show-ahead.
  - mem_addr/mem_data always reflect the head entry.
  - They must hold stable while mem_wr=1 and mem_ready=0.
- Pop: occurs on an edge where mem_wr=1 and mem_ready=1. mem_ready while empty is ignored.
- Push: occurs on an edge where WEN=1 and state is IDLE or RUN.
  - Accepted if FIFO not full, or if full with a pop on the same edge.
  - Otherwise the sample is dropped and ovf is set (sticky until reset).
- Latency: a sample pushed into an empty FIFO at edge N drives mem_wr=1 in the cycle after edge N.
- Occupancy counter: width log2(DEPTH)+1. A simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- sample_cnt: +1 per accepted push; saturates at 2^AW-1; dropped samples are not counted.
- peak: on each accepted push, |Yn| is compared and kept if larger.
  - |Yn| = Yn if Yn>=0, else -Yn.
  - -32768 saturates to 32767 (0x7FFF).
- State machine (2-bit): IDLE, RUN, DRAIN, DONE.
  - IDLE: on WEN=1 (sample pushed) -> RUN. If Finish=1 in the same cycle, go DRAIN instead. Finish=1 with no WEN -> DONE (empty stream).
  - RUN: Finish=1 -> DRAIN. A WEN sample present on that same edge is still pushed.
  - DRAIN: pushes ignored (WEN does not set ovf). Go DONE on the edge where occupancy becomes 0: either already 0, or 1 with a pop.
  - DONE: done=1; terminal until reset. WEN/mem_ready ignored; mem_wr=0.
- done is registered: it asserts the cycle after the final pop edge. mem_wr is 0 in that same cycle.
- Finish deasserting after it has been seen has no effect.
- Reset mid-operation: buffered samples are discarded; no further mem_wr until new WEN after release.
- No combinational path from WEN/Yn to any output. mem_wr depends only on registered state.

Test Plan:
- Reset/idle: hold rst=0 with WEN/Finish random -> all outputs 0; release, no WEN -> mem_wr stays 0, state IDLE.
- Streaming, mem_ready=1: WEN=1 for 5 cycles, Yn=10,-20,30,-40,5, WAddr=0..4 -> mem_wr rises one cycle after first WEN; writes (0,10),(1,-20),(2,30),(3,-40),(4,5) in order; sample_cnt=5; peak=40; ovf=0.
- Back-pressure: mem_ready=0, 9 consecutive WEN samples -> first 8 stored; 9th dropped with ovf=1; sample_cnt=8. Raise mem_ready -> 8 writes in order with head held stable while stalled.
- Full plus simultaneous push/pop: FIFO full, mem_ready=1 and WEN=1 on the same edge -> push accepted, ovf stays 0, occupancy stays 8.
- Finish drain: 3 entries pending with mem_ready=0, Finish=1 plus WEN on the same edge -> 4 entries. WEN during DRAIN is ignored with ovf unchanged. mem_ready=1 -> 4 writes, then done=1 the cycle after the last pop.
- Edge cases: Yn=-32768 accepted -> peak=0x7FFF. Finish with no samples ever -> done=1 one cycle later. rst=0 during DRAIN -> immediate clear, done=0, mem_wr=0.

Source files
------------

// File: rtl/iir_out_buffer.sv
// Output buffer after the IIR filter: a show-ahead FIFO of {WAddr, Yn} drained to
// result memory over a valid/ready port, plus sample count, peak and overflow tracking.
module iir_out_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 20,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WEN,
  input  logic [DW-1:0] Yn,
  input  logic [AW-1:0] WAddr,
  input  logic          Finish,
  input  logic          mem_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          ovf,
  output logic [DW-1:0] peak,
  output logic [AW-1:0] sample_cnt,
  output logic          done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count, count_nxt;
  logic                 empty, full, accepting, push, pop, drop;
  logic signed [DW-1:0] yn_s;
  logic [DW-1:0]        yn_mag;

  // Magnitude of a two's-complement sample; the most negative code clamps to max positive.
  function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] neg;
    if (v == {1'b1, {(DW-1){1'b0}}}) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (v[DW-1]) begin
      neg = -v;
      return $unsigned(neg);
    end else begin
      return $unsigned(v);
    end
  endfunction

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign yn_s   = $signed(Yn);
  assign yn_mag = sat_abs(yn_s);

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign mem_wr    = !empty;
  assign pop       = mem_wr && mem_ready;
  assign accepting = (state == IDLE) || (state == RUN);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push      = WEN && accepting && (!full || pop);
  assign drop      = WEN && accepting && full && !pop;

  // Head is masked while empty so the port idles at zero, including out of reset.
  assign mem_addr = empty ? '0 : addr_mem[rd_ptr];
  assign mem_data = empty ? '0 : data_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= WAddr;
      data_mem[wr_ptr] <= Yn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      peak       <= '0;
      sample_cnt <= '0;
      done       <= 1'b0;
      state      <= IDLE;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= (state_nxt == DONE);
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        sample_cnt <= sat_inc(sample_cnt);
        if (yn_mag > peak) begin
          peak <= yn_mag;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (WEN) begin
          state_nxt = Finish ? DRAIN : RUN;
        end else if (Finish) begin
          state_nxt = DONE;
        end
      end
      RUN: begin
        if (Finish) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (count_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iir_out_buffer.sv
// Directed bench for iir_out_buffer: a streaming vector table plus hand-written
// sequences for back-pressure, full push/pop, finish drain and reset corners.
module tb_iir_out_buffer;

  logic        clk;
  logic        rst;
  logic        WEN;
  logic [15:0] Yn;
  logic [19:0] WAddr;
  logic        Finish;
  logic        mem_ready;
  logic        mem_wr;
  logic [19:0] mem_addr;
  logic [15:0] mem_data;
  logic        ovf;
  logic [15:0] peak;
  logic [19:0] sample_cnt;
  logic        done;

  int nvec;
  int nerr;

  iir_out_buffer #(.DEPTH(8), .AW(20), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .WEN        (WEN),
    .Yn         (Yn),
    .WAddr      (WAddr),
    .Finish     (Finish),
    .mem_ready  (mem_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .ovf        (ovf),
    .peak       (peak),
    .sample_cnt (sample_cnt),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] yn;
    logic [19:0] waddr;
    logic        finish;
    logic        ready;
    logic        exp_wr;
    logic [19:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic [15:0] exp_peak;
    logic [19:0] exp_cnt;
    logic        exp_done;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input string name, input logic [19:0] a, input logic [15:0] d);
    chk({name, ".wr"}, 32'(mem_wr), 32'd1);
    chk({name, ".addr"}, 32'(mem_addr), 32'(a));
    chk({name, ".data"}, 32'(mem_data), 32'(d));
  endtask

  task automatic chk_stat(input string name, input logic w, input logic o, input logic [15:0] p,
                          input logic [19:0] c, input logic dn);
    chk({name, ".wr"}, 32'(mem_wr), 32'(w));
    chk({name, ".ovf"}, 32'(ovf), 32'(o));
    chk({name, ".peak"}, 32'(peak), 32'(p));
    chk({name, ".cnt"}, 32'(sample_cnt), 32'(c));
    chk({name, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic drive(input logic w, input logic [15:0] y, input logic [19:0] a,
                       input logic f, input logic r);
    WEN = w; Yn = y; WAddr = a; Finish = f; mem_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between clock edges; caller sits just after an edge.
  task automatic do_reset();
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    tbl[0] = '{1'b1, 16'd10,    20'd0, 1'b0, 1'b1, 1'b1, 20'd0, 16'd10,    1'b0, 16'd10, 20'd1, 1'b0};
    tbl[1] = '{1'b1, 16'hFFEC,  20'd1, 1'b0, 1'b1, 1'b1, 20'd1, 16'hFFEC,  1'b0, 16'd20, 20'd2, 1'b0};
    tbl[2] = '{1'b1, 16'd30,    20'd2, 1'b0, 1'b1, 1'b1, 20'd2, 16'd30,    1'b0, 16'd30, 20'd3, 1'b0};
    tbl[3] = '{1'b1, 16'hFFD8,  20'd3, 1'b0, 1'b1, 1'b1, 20'd3, 16'hFFD8,  1'b0, 16'd40, 20'd4, 1'b0};
    tbl[4] = '{1'b1, 16'd5,     20'd4, 1'b0, 1'b1, 1'b1, 20'd4, 16'd5,     1'b0, 16'd40, 20'd5, 1'b0};
    tbl[5] = '{1'b0, 16'd0,     20'd0, 1'b0, 1'b1, 1'b0, 20'd0, 16'd0,     1'b0, 16'd40, 20'd5, 1'b0};

    // Reset held with noisy inputs
    rst = 1'b0;
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(1)), 16'($urandom), 20'($urandom), 1'($urandom_range(1)),
            1'($urandom_range(1)));
      step();
      chk_stat("rst_hold", 1'b0, 1'b0, 16'd0, 20'd0, 1'b0);
      chk("rst_hold.addr", 32'(mem_addr), 32'd0);
      chk("rst_hold.data", 32'(mem_data), 32'd0);
    end
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_stat("idle", 1'b0, 1'b0, 16'd0, 20'd0, 1'b0);
    end

    // Streaming with mem_ready=1
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].wen, tbl[i].yn, tbl[i].waddr, tbl[i].finish, tbl[i].ready);
      step();
      chk_stat($sformatf("stream%0d", i), tbl[i].exp_wr, tbl[i].exp_ovf, tbl[i].exp_peak,
               tbl[i].exp_cnt, tbl[i].exp_done);
      if (tbl[i].exp_wr) chk_head($sformatf("stream%0d", i), tbl[i].exp_addr, tbl[i].exp_data);
    end

    // Back-pressure: 9 samples into 8 entries
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 16'(i + 1), 20'(32 + i), 1'b0, 1'b0);
      step();
      chk_head($sformatf("bp_fill%0d", i), 20'd32, 16'd1);
      chk($sformatf("bp_fill%0d.ovf", i), 32'(ovf), (i == 8) ? 32'd1 : 32'd0);
    end
    chk_stat("bp_full", 1'b1, 1'b1, 16'd8, 20'd8, 1'b0);
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_head("bp_stall", 20'd32, 16'd1);
    end
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("bp_drain%0d", k), 20'(32 + k), 16'(k + 1));
      step();
    end
    chk_stat("bp_empty", 1'b0, 1'b1, 16'd8, 20'd8, 1'b0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i + 1), 20'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 16'd50, 20'd99, 1'b0, 1'b1);
    step();
    chk_stat("fpp", 1'b1, 1'b0, 16'd50, 20'd9, 1'b0);
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      chk_head($sformatf("fpp_drain%0d", k), 20'(k), 16'(k + 1));
      step();
    end
    chk_head("fpp_last", 20'd99, 16'd50);
    step();
    chk_stat("fpp_empty", 1'b0, 1'b0, 16'd50, 20'd9, 1'b0);

    // Finish with a same-edge sample, then drain to done
    do_reset();
    drive(1'b1, 16'd7, 20'd10, 1'b0, 1'b0);     step();
    drive(1'b1, 16'hFFFD, 20'd11, 1'b0, 1'b0);  step();
    drive(1'b1, 16'd2, 20'd12, 1'b0, 1'b0);     step();
    drive(1'b1, 16'hFFF7, 20'd13, 1'b1, 1'b0);  step();
    chk_stat("fin_edge", 1'b1, 1'b0, 16'd9, 20'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'd1000, 20'd77, 1'b0, 1'b0);
      step();
      chk_stat("drain_wen", 1'b1, 1'b0, 16'd9, 20'd4, 1'b0);
      chk_head("drain_wen", 20'd10, 16'd7);
    end
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b1);
    chk_head("drain0", 20'd10, 16'd7);     step();
    chk_head("drain1", 20'd11, 16'hFFFD);  step();
    chk_head("drain2", 20'd12, 16'd2);     step();
    chk_head("drain3", 20'd13, 16'hFFF7);
    chk("drain3.done", 32'(done), 32'd0);
    step();
    chk_stat("done", 1'b0, 1'b0, 16'd9, 20'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd3, 20'd5, 1'b0, 1'b1);
      step();
      chk_stat("done_hold", 1'b0, 1'b0, 16'd9, 20'd4, 1'b1);
    end

    // Most negative sample saturates the peak
    do_reset();
    drive(1'b1, 16'h8000, 20'd5, 1'b0, 1'b1);
    step();
    chk_stat("neg_max", 1'b1, 1'b0, 16'h7FFF, 20'd1, 1'b0);
    chk_head("neg_max", 20'd5, 16'h8000);

    // Finish on an empty stream
    do_reset();
    step();
    chk("empty_fin.pre", 32'(done), 32'd0);
    drive(1'b0, 16'd0, 20'd0, 1'b1, 1'b0);
    step();
    chk_stat("empty_fin", 1'b0, 1'b0, 16'd0, 20'd0, 1'b1);

    // Reset asserted while draining
    do_reset();
    drive(1'b1, 16'd4, 20'd1, 1'b0, 1'b0);  step();
    drive(1'b1, 16'd6, 20'd2, 1'b0, 1'b0);  step();
    drive(1'b0, 16'd0, 20'd0, 1'b1, 1'b0);  step();
    chk_stat("pre_rst", 1'b1, 1'b0, 16'd6, 20'd2, 1'b0);
    rst = 1'b0;
    #1;
    chk_stat("mid_rst", 1'b0, 1'b0, 16'd0, 20'd0, 1'b0);
    drive(1'b0, 16'd0, 20'd0, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_stat("post_rst", 1'b0, 1'b0, 16'd0, 20'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
